// File: rtl/wb_retire_buf.sv
// Write-back retire buffer: accepts MEM->WB instructions into an in-order FIFO,
// drains them to an arbitrated register-file write port, forwards pending rd
// values to decode/execute and keeps a running retired-instruction count.
module wb_retire_buf #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RETCNT_W = 64
) (
  input  logic                clk,
  input  logic                rst_b,
  output logic                wb_pipe_ready,
  input  logic                wb_pipe_valid,
  input  logic [XLEN-1:0]     wb_pipe_pc,
  input  logic [XLEN-1:0]     wb_pipe_instruction,
  input  logic                wb_pipe_rd_write,
  input  logic [REG_AW-1:0]   wb_pipe_rd_addr,
  input  logic [XLEN-1:0]     wb_pipe_rd_data,
  input  logic                wb_kill,
  input  logic                wb_rf_grant,
  output logic                wb_rd_write,
  output logic [REG_AW-1:0]   wb_rd_addr,
  output logic [XLEN-1:0]     wb_rd_wdata,
  output logic                wb_retire_valid,
  output logic [XLEN-1:0]     wb_retire_pc,
  output logic [RETCNT_W-1:0] wb_retire_cnt,
  input  logic [REG_AW-1:0]   wb_fwd_rs1_addr,
  input  logic [REG_AW-1:0]   wb_fwd_rs2_addr,
  output logic                wb_fwd_rs1_hit,
  output logic [XLEN-1:0]     wb_fwd_rs1_data,
  output logic                wb_fwd_rs2_hit,
  output logic [XLEN-1:0]     wb_fwd_rs2_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              rd_write;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              push_entry;
  entry_t              head;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [RETCNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [PTR_W-1:0]    age_idx [DEPTH];
  logic                full, empty, push, pop, head_need_wr;

  // The instruction word is carried by the pipe but never stored.
  logic unused_instr;
  assign unused_instr = ^wb_pipe_instruction;

  // Status flags and the push/pop handshake; kill overrides both.
  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    empty        = (count_q == '0);
    head         = mem_q[rd_ptr_q];
    head_need_wr = head.rd_write & (head.rd_addr != '0);
    push         = wb_pipe_valid & ~full & ~wb_kill;
    pop          = ~empty & ~wb_kill & (wb_rf_grant | ~head_need_wr);
  end

  // Pack the incoming instruction into a FIFO entry.
  always_comb begin
    push_entry          = '0;
    push_entry.pc       = wb_pipe_pc;
    push_entry.rd_write = wb_pipe_rd_write;
    push_entry.rd_addr  = wb_pipe_rd_addr;
    push_entry.rd_data  = wb_pipe_rd_data;
  end

  // Retire and register-file write outputs, idle unless the head pops.
  always_comb begin
    wb_pipe_ready   = ~full;
    wb_retire_valid = pop;
    wb_retire_pc    = '0;
    wb_rd_write     = 1'b0;
    wb_rd_addr      = '0;
    wb_rd_wdata     = '0;
    if (pop) begin
      wb_retire_pc = head.pc;
      wb_rd_write  = head_need_wr;
      wb_rd_addr   = head.rd_addr;
      wb_rd_wdata  = head.rd_data;
    end
    wb_retire_cnt = ret_cnt_q;
  end

  // Next-state for pointers, occupancy and the retire counter.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ret_cnt_d = ret_cnt_q;
    if (wb_kill) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        ret_cnt_d = ret_cnt_q + RETCNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ret_cnt_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // Entry storage; validity is tracked by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  // Physical slot of the i-th oldest entry.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age_idx[i] = rd_ptr_q + PTR_W'(i);
    end
  end

  // Forwarding scan, oldest to youngest so the youngest match wins; x0 never hits.
  always_comb begin
    wb_fwd_rs1_hit  = 1'b0;
    wb_fwd_rs1_data = '0;
    wb_fwd_rs2_hit  = 1'b0;
    wb_fwd_rs2_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && mem_q[age_idx[i]].rd_write) begin
        if ((wb_fwd_rs1_addr != '0) && (mem_q[age_idx[i]].rd_addr == wb_fwd_rs1_addr)) begin
          wb_fwd_rs1_hit  = 1'b1;
          wb_fwd_rs1_data = mem_q[age_idx[i]].rd_data;
        end
        if ((wb_fwd_rs2_addr != '0) && (mem_q[age_idx[i]].rd_addr == wb_fwd_rs2_addr)) begin
          wb_fwd_rs2_hit  = 1'b1;
          wb_fwd_rs2_data = mem_q[age_idx[i]].rd_data;
        end
      end
    end
  end

endmodule
